flight_cmd_ctrl: RTL and testbench
==================================

// Module: flight_cmd_ctrl
// PURPOSE
//  Command sequencer between UART_wrapper (decoded 8b cmd + 16b data) and flght_cntrl/inertial_integrator.
//  Latches pitch/roll/yaw/thrust setpoints and sequences motor spin-up, then inertial calibration.
//  Handles emergency landing and motors-off, and returns the 8'hA5 ack for each accepted command.
//  A no-command watchdog forces an emergency landing if the remote link goes silent.
// PARAMETERS
//  FAST_SIM  1  1: shortened timers for simulation (SPIN_W=9, WD_W=12); 0: SPIN_W=26, WD_W=27
// PORTS
//  clk           in   1   system clock
//  RST_n         in   1   asynchronous active-low reset
//  cmd_rdy       in   1   UART_wrapper holds a complete command
//  cmd           in   8   command opcode (encodings in quad_cmd_pkg)
//  data          in   16  command payload
//  clr_cmd_rdy   out  1   1-cycle consume strobe back to UART_wrapper
//  resp          out  8   response byte, constant 8'hA5
//  send_resp     out  1   1-cycle strobe: transmit resp
//  d_ptch        out  16  desired pitch (signed)
//  d_roll        out  16  desired roll (signed)
//  d_yaw         out  16  desired yaw (signed)
//  thrst         out  9   desired thrust (unsigned)
//  strt_cal      out  1   1-cycle pulse: start inertial calibration
//  inertial_cal  out  1   high from CALIBRATE accept until cal_done (holds motors at cal speed)
//  cal_done      in   1   inertial_integrator calibration complete (1-cycle pulse)
//  motors_off    out  1   force ESC outputs to zero
// BEHAVIOUR
//  Reset (async): setpoints=0, thrst=0, motors_off=1, inertial_cal=0, strt_cal=0, send_resp=0, state IDLE, timers 0.
//  FSM states: IDLE, SPINUP, CAL, ACK.
//  IDLE & cmd_rdy: clr_cmd_rdy=1 combinationally that cycle; decode at the same edge:
//   SET_PTCH/SET_ROLL/SET_YAW: load d_* <= data; -> ACK.   SET_THRST: thrst <= data[8:0] (upper bits dropped); -> ACK.
//   E_LAND: d_ptch=d_roll=d_yaw=0, thrst=0; -> ACK.     MTRS_OFF: motors_off<=1; -> ACK.
//   CALIBRATE: motors_off<=0, inertial_cal<=1, spin timer cleared; -> SPINUP.
//   Any other opcode: consumed (clr_cmd_rdy), no ack, no state change.
//  SPINUP: spin timer (SPIN_W bits) counts; at all-ones: strt_cal pulses 1 cycle -> CAL.
//  CAL: wait cal_done; on cal_done: inertial_cal<=0 -> ACK.
//  ACK: send_resp=1 for exactly one cycle -> IDLE. Ack latency: send_resp high the cycle after clr_cmd_rdy (set cmds).
//  cmd_rdy while in SPINUP/CAL/ACK: not consumed (clr_cmd_rdy=0); held by UART_wrapper until IDLE.
//  cal_done outside CAL: ignored.
//  Watchdog (WD_W bits): cleared whenever cmd_rdy=1; else increments, saturating.
//   On reaching all-ones: zero d_*/thrst (E_LAND effect), no ack, counter stays saturated until next cmd_rdy.
//   Watchdog is inhibited (held clear) while motors_off=1 or state is SPINUP/CAL.
//  Only CALIBRATE clears motors_off; a CALIBRATE while already calibrated restarts full spin-up + cal.
//  RST_n low mid-sequence: immediate return to reset values, including motors_off=1 and inertial_cal=0.
//  resp: constant 8'hA5 at all times, including reset.
// STRUCTURE
//  quad_cmd_pkg: cmd_t enum {SET_PTCH=8'h02, SET_ROLL=8'h03, SET_YAW=8'h04, SET_THRST=8'h05,
//   CALIBRATE=8'h06, E_LAND=8'h07, MTRS_OFF=8'h08}, ACK_BYTE=8'hA5, fsm state_t.
//  The package is shared with UART_wrapper, RemoteComm and the testbench task library.
//  One sub-module: sat_timer #(W) (clear, enable, all-ones flag); used twice (spin-up, watchdog).
// TESTING
//  1 Reset -> motors_off=1, thrst=0, d_*=0; CALIBRATE -> inertial_cal=1, motors_off=0;
//    strt_cal fires 511 cycles later (FAST_SIM); cal_done -> one send_resp, resp=8'hA5.
//  2 SET_PTCH 16'h00AA / SET_YAW 16'h0099 / SET_ROLL 16'hFF66 -> d_* match exactly.
//    Each command gets one clr_cmd_rdy and one send_resp, send_resp one cycle after clr_cmd_rdy.
//  3 SET_THRST 16'h01AA -> thrst=9'h1AA; then E_LAND -> all setpoints 0 and acked.
//  4 cmd_rdy=1 (SET_PTCH 16'h0010) held during CAL -> clr_cmd_rdy stays 0 until after the
//    calibration ack; the command is then applied.
//  5 thrst=9'h080, no cmd for 4095 cycles -> setpoints forced 0 with no send_resp;
//    MTRS_OFF then -> motors_off=1, and the watchdog stays idle.
//  6 Opcode 8'h3C -> consumed with no ack and no change; RST_n low during SPINUP -> reset values,
//    and no strt_cal pulse follows.

Source files
------------

// File: rtl/quad_cmd_pkg.sv
// Shared command encodings, ack byte and sequencer states for the quad flight command path.
package quad_cmd_pkg;

    typedef enum logic [7:0] {
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        SET_THRST = 8'h05,
        CALIBRATE = 8'h06,
        E_LAND    = 8'h07,
        MTRS_OFF  = 8'h08
    } cmd_t;

    localparam logic [7:0] ACK_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPINUP,
        ST_CAL,
        ST_ACK
    } state_t;

endpackage

// File: rtl/sat_timer.sv
// Saturating up-counter with synchronous clear; flags when it sits at all-ones.
module sat_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [W-1:0] cnt_q, cnt_d;

    assign full = &cnt_q;

    // Clear wins over count; counting stops once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !full)
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/flight_cmd_ctrl.sv
// Command sequencer: latches setpoints from decoded UART commands, sequences
// spin-up and inertial calibration, acks with 8'hA5 and lands on link loss.
module flight_cmd_ctrl
    import quad_cmd_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    input  logic        cal_done,
    output logic        motors_off
);

    localparam int SPIN_W = FAST_SIM ? 9  : 26;
    localparam int WD_W   = FAST_SIM ? 12 : 27;

    state_t      state_q, state_d;
    logic [15:0] d_ptch_q, d_ptch_d;
    logic [15:0] d_roll_q, d_roll_d;
    logic [15:0] d_yaw_q, d_yaw_d;
    logic [8:0]  thrst_q, thrst_d;
    logic        motors_off_q, motors_off_d;
    logic        inertial_cal_q, inertial_cal_d;

    logic        spin_clr, spin_full;
    logic        wd_clr, wd_full;

    // Spin-up timer runs only in SPINUP and is restarted by each accepted CALIBRATE.
    sat_timer #(.W(SPIN_W)) u_spin_tmr (
        .clk   (clk),
        .rst_n (RST_n),
        .clr   (spin_clr),
        .en    (state_q == ST_SPINUP),
        .full  (spin_full)
    );

    // Link-loss watchdog: any pending command is proof of life; it is parked
    // while the motors are off or a spin-up/calibration is in progress.
    assign wd_clr = cmd_rdy || motors_off_q ||
                    (state_q == ST_SPINUP) || (state_q == ST_CAL);

    sat_timer #(.W(WD_W)) u_wd_tmr (
        .clk   (clk),
        .rst_n (RST_n),
        .clr   (wd_clr),
        .en    (1'b1),
        .full  (wd_full)
    );

    assign resp         = ACK_BYTE;
    assign d_ptch       = d_ptch_q;
    assign d_roll       = d_roll_q;
    assign d_yaw        = d_yaw_q;
    assign thrst        = thrst_q;
    assign motors_off   = motors_off_q;
    assign inertial_cal = inertial_cal_q;

    // Next-state, command decode and strobes.
    always_comb begin
        state_d        = state_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        motors_off_d   = motors_off_q;
        inertial_cal_d = inertial_cal_q;
        clr_cmd_rdy    = 1'b0;
        send_resp      = 1'b0;
        strt_cal       = 1'b0;
        spin_clr       = 1'b0;

        // Silent link: land. A command decoded below in the same cycle overrides.
        if (wd_full) begin
            d_ptch_d = '0;
            d_roll_d = '0;
            d_yaw_d  = '0;
            thrst_d  = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    case (cmd)
                        SET_PTCH: begin
                            d_ptch_d = data;
                            state_d  = ST_ACK;
                        end
                        SET_ROLL: begin
                            d_roll_d = data;
                            state_d  = ST_ACK;
                        end
                        SET_YAW: begin
                            d_yaw_d = data;
                            state_d = ST_ACK;
                        end
                        SET_THRST: begin
                            thrst_d = data[8:0];
                            state_d = ST_ACK;
                        end
                        E_LAND: begin
                            d_ptch_d = '0;
                            d_roll_d = '0;
                            d_yaw_d  = '0;
                            thrst_d  = '0;
                            state_d  = ST_ACK;
                        end
                        MTRS_OFF: begin
                            motors_off_d = 1'b1;
                            state_d      = ST_ACK;
                        end
                        CALIBRATE: begin
                            motors_off_d   = 1'b0;
                            inertial_cal_d = 1'b1;
                            spin_clr       = 1'b1;
                            state_d        = ST_SPINUP;
                        end
                        default: ;  // unknown opcode: swallowed silently
                    endcase
                end
            end
            ST_SPINUP: begin
                if (spin_full) begin
                    strt_cal = 1'b1;
                    state_d  = ST_CAL;
                end
            end
            ST_CAL: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK: begin
                send_resp = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and setpoint registers; reset leaves the motors off.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q        <= ST_IDLE;
            d_ptch_q       <= '0;
            d_roll_q       <= '0;
            d_yaw_q        <= '0;
            thrst_q        <= '0;
            motors_off_q   <= 1'b1;
            inertial_cal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            motors_off_q   <= motors_off_d;
            inertial_cal_q <= inertial_cal_d;
        end
    end

endmodule

// File: tb/tb_flight_cmd_ctrl.sv
// Directed bench for flight_cmd_ctrl: vector table for setpoint commands plus
// hand-written sequences for calibration, held commands, watchdog and reset.
module tb_flight_cmd_ctrl;
    import quad_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        RST_n = 1'b1;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;

    int nchk = 0;
    int nfail = 0;

    flight_cmd_ctrl #(.FAST_SIM(1'b1)) dut (
        .clk(clk), .RST_n(RST_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
        .strt_cal(strt_cal), .inertial_cal(inertial_cal), .cal_done(cal_done),
        .motors_off(motors_off)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a command from a negedge, wait for consume, then drop cmd_rdy.
    // got_ack is send_resp in the cycle after clr_cmd_rdy; ack_tail the cycle after that.
    task automatic send_cmd(input logic [7:0] op, input logic [15:0] d,
                            output logic got_clr, output logic got_ack, output logic ack_tail);
        int n;
        @(negedge clk);
        cmd = op; data = d; cmd_rdy = 1'b1;
        #1;
        n = 0;
        while (!clr_cmd_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        got_clr = clr_cmd_rdy;
        @(negedge clk);
        cmd_rdy = 1'b0;
        got_ack = send_resp;
        @(negedge clk);
        ack_tail = send_resp;
    endtask

    // Issue CALIBRATE and return the number of cycles from consume to strt_cal.
    task automatic cal_spin(output int lat);
        @(negedge clk);
        cmd = CALIBRATE; data = 16'h0; cmd_rdy = 1'b1;
        #1;
        check("cal_clr", clr_cmd_rdy, 1);
        lat = 0;
        do begin
            @(negedge clk);
            cmd_rdy = 1'b0;
            lat++;
        end while (!strt_cal && lat < 2000);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic        ack;
        logic [15:0] p, r, y;
        logic [8:0]  t;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic c, a, tl;
        int lat, nclr, nresp, nstrt, n;

        tbl[0] = '{SET_PTCH,  16'h00AA, 1'b1, 16'h00AA, 16'h0000, 16'h0000, 9'h000};
        tbl[1] = '{SET_YAW,   16'h0099, 1'b1, 16'h00AA, 16'h0000, 16'h0099, 9'h000};
        tbl[2] = '{SET_ROLL,  16'hFF66, 1'b1, 16'h00AA, 16'hFF66, 16'h0099, 9'h000};
        tbl[3] = '{SET_THRST, 16'h01AA, 1'b1, 16'h00AA, 16'hFF66, 16'h0099, 9'h1AA};
        tbl[4] = '{8'h3C,     16'h1234, 1'b0, 16'h00AA, 16'hFF66, 16'h0099, 9'h1AA};
        tbl[5] = '{SET_THRST, 16'hFE80, 1'b1, 16'h00AA, 16'hFF66, 16'h0099, 9'h080};
        tbl[6] = '{E_LAND,    16'h5555, 1'b1, 16'h0000, 16'h0000, 16'h0000, 9'h000};

        // Reset state
        #2 RST_n = 1'b0;
        #1;
        check("rst_motors_off", motors_off, 1);
        check("rst_thrst", thrst, 0);
        check("rst_dptch", d_ptch, 0);
        check("rst_droll", d_roll, 0);
        check("rst_dyaw", d_yaw, 0);
        check("rst_inertial_cal", inertial_cal, 0);
        check("rst_send_resp", send_resp, 0);
        check("rst_strt_cal", strt_cal, 0);
        check("rst_resp", resp, 8'hA5);
        repeat (3) @(negedge clk);
        RST_n = 1'b1;

        // Calibration: 1 consume cycle + 511 SPINUP cycles, strt_cal in the 512th.
        cal_spin(lat);
        check("spin_latency", lat, 512);
        check("cal_inertial", inertial_cal, 1);
        check("cal_motors_on", motors_off, 0);
        @(negedge clk);
        check("strt_cal_1cyc", strt_cal, 0);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("cal_ack", send_resp, 1);
        check("cal_ack_resp", resp, 8'hA5);
        check("cal_inertial_off", inertial_cal, 0);
        @(negedge clk);
        check("cal_ack_1cyc", send_resp, 0);

        // Setpoint vector table
        for (int i = 0; i < 7; i++) begin
            send_cmd(tbl[i].op, tbl[i].d, c, a, tl);
            check($sformatf("v%0d_clr", i), c, 1);
            check($sformatf("v%0d_ack", i), a, tbl[i].ack);
            check($sformatf("v%0d_ack_tail", i), tl, 0);
            check($sformatf("v%0d_ptch", i), d_ptch, tbl[i].p);
            check($sformatf("v%0d_roll", i), d_roll, tbl[i].r);
            check($sformatf("v%0d_yaw", i), d_yaw, tbl[i].y);
            check($sformatf("v%0d_thrst", i), thrst, tbl[i].t);
            check($sformatf("v%0d_motors_off", i), motors_off, 0);
        end

        // cal_done outside CAL is ignored
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("stray_cal_done_resp", send_resp, 0);
        check("stray_cal_done_ical", inertial_cal, 0);

        // Command held through calibration is not consumed until after the cal ack
        cal_spin(lat);
        check("recal_latency", lat, 512);
        @(negedge clk);
        cmd = SET_PTCH; data = 16'h0010; cmd_rdy = 1'b1;
        nclr = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (clr_cmd_rdy) nclr++;
            @(negedge clk);
        end
        check("held_no_clr_cal", nclr, 0);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("held_cal_ack", send_resp, 1);
        check("held_no_clr_ack", clr_cmd_rdy, 0);
        @(negedge clk);
        check("held_clr_idle", clr_cmd_rdy, 1);
        @(negedge clk);
        cmd_rdy = 1'b0;
        check("held_ack", send_resp, 1);
        check("held_ptch", d_ptch, 16'h0010);

        // Watchdog: silence with motors on forces setpoints to zero, no ack
        send_cmd(SET_THRST, 16'h0080, c, a, tl);
        check("wd_thrst_set", thrst, 9'h080);
        nresp = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (send_resp) nresp++;
        end
        check("wd_not_yet", thrst, 9'h080);
        n = 0;
        while (thrst != 0 && n < 300) begin
            @(negedge clk);
            if (send_resp) nresp++;
            n++;
        end
        check("wd_thrst_zero", thrst, 0);
        check("wd_ptch_zero", d_ptch, 0);
        check("wd_no_resp", nresp, 0);

        // Motors off parks the watchdog
        send_cmd(MTRS_OFF, 16'h0, c, a, tl);
        check("mtrs_off_ack", a, 1);
        check("mtrs_off", motors_off, 1);
        send_cmd(SET_THRST, 16'h0055, c, a, tl);
        repeat (4300) @(negedge clk);
        check("wd_idle_thrst", thrst, 9'h055);
        check("wd_idle_motors", motors_off, 1);

        // Async reset during SPINUP
        @(negedge clk);
        cmd = CALIBRATE; cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        repeat (100) @(negedge clk);
        check("spin_ical", inertial_cal, 1);
        #2 RST_n = 1'b0;
        #1;
        check("midrst_motors_off", motors_off, 1);
        check("midrst_ical", inertial_cal, 0);
        check("midrst_thrst", thrst, 0);
        @(negedge clk);
        RST_n = 1'b1;
        nstrt = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (strt_cal) nstrt++;
        end
        check("midrst_no_strt_cal", nstrt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
